// File: rtl/priv_trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : priv_trap_controller
//  Description : Machine-mode trap sequencer. Prioritises exceptions and
//                enabled interrupts, latches cause/epc/tval and the trap
//                vector target, waits for the pipeline to drain, then issues
//                a one-cycle PC redirect with a CSR update strobe. Also
//                sequences mret and produces the wfi commit stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module priv_trap_controller #(
    parameter  int NUM_EXTENSIONS   = 1,
    parameter  int RMGMT_CAUSE_BASE = 24,
    localparam int C_RMGMT_W        = (NUM_EXTENSIONS > 1) ? $clog2(NUM_EXTENSIONS) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 fault_insn,
    input  logic                 mal_insn,
    input  logic                 illegal_insn,
    input  logic                 fault_l,
    input  logic                 mal_l,
    input  logic                 fault_s,
    input  logic                 mal_s,
    input  logic                 breakpoint,
    input  logic                 env,
    input  logic                 prot_fault_i,
    input  logic                 prot_fault_l,
    input  logic                 prot_fault_s,
    input  logic                 ex_rmgmt,
    input  logic [C_RMGMT_W-1:0] ex_rmgmt_cause,
    input  logic                 ret,
    input  logic                 wfi,
    input  logic [31:0]          epc,
    input  logic [31:0]          badaddr,
    input  logic                 pipe_clear,
    input  logic                 timer_int,
    input  logic                 soft_int,
    input  logic                 ext_int,
    input  logic                 mstatus_mie,
    input  logic [2:0]           mie_bits,
    input  logic [31:0]          mtvec,
    input  logic [31:0]          mepc_r,
    output logic                 intr,
    output logic                 insert_pc,
    output logic [31:0]          priv_pc,
    output logic                 trap_we,
    output logic                 mret_we,
    output logic [31:0]          trap_cause,
    output logic [31:0]          trap_epc,
    output logic [31:0]          trap_tval,
    output logic                 wfi_stall
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_TRAP_WAIT = 2'd1;
    localparam logic [1:0] c_RET_WAIT  = 2'd2;
    localparam logic [1:0] c_REDIRECT  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_ip;
    logic [2:0]  w_ip_masked;
    logic        w_int_en;
    logic        w_fault_i;
    logic        w_fault_l;
    logic        w_fault_s;
    logic        w_any_exc;
    logic        w_take_trap;
    logic        w_take_ret;
    logic [31:0] w_cause;
    logic [31:0] w_tval;
    logic [31:0] w_target;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic [31:0] r_target;
    logic        r_from_trap;

    assign w_fault_i   = fault_insn | prot_fault_i;
    assign w_fault_l   = fault_l    | prot_fault_l;
    assign w_fault_s   = fault_s    | prot_fault_s;
    assign w_any_exc   = w_fault_i | illegal_insn | mal_insn | env | breakpoint |
                         mal_s | mal_l | w_fault_s | w_fault_l | ex_rmgmt;
    assign w_ip_masked = r_ip & mie_bits;
    assign w_int_en    = (|w_ip_masked) & mstatus_mie;
    assign w_take_trap = (r_state == c_IDLE) & (w_any_exc | w_int_en);
    assign w_take_ret  = (r_state == c_IDLE) & ~w_take_trap & ret;

    // Interrupt lines are sampled once per cycle; bit order {ext, timer, soft}
    always_ff @(posedge CLK) begin
        if (!nRST) r_ip <= 3'b000;
        else       r_ip <= {ext_int, timer_int, soft_int};
    end

    // Cause/tval selection by fixed priority; exceptions beat interrupts
    always_comb begin
        w_cause = 32'd0;
        w_tval  = 32'd0;
        if (w_any_exc) begin
            if      (w_fault_i)    w_cause = 32'd1;
            else if (illegal_insn) w_cause = 32'd2;
            else if (mal_insn)     w_cause = 32'd0;
            else if (env)          w_cause = 32'd11;
            else if (breakpoint)   w_cause = 32'd3;
            else if (mal_s)        w_cause = 32'd6;
            else if (mal_l)        w_cause = 32'd4;
            else if (w_fault_s)    w_cause = 32'd7;
            else if (w_fault_l)    w_cause = 32'd5;
            else                   w_cause = 32'(RMGMT_CAUSE_BASE) + 32'(ex_rmgmt_cause);
            case (w_cause)
                32'd0, 32'd1, 32'd4, 32'd5, 32'd6, 32'd7: w_tval = badaddr;
                32'd3:                                    w_tval = epc;
                default:                                  w_tval = 32'd0;
            endcase
        end else begin
            if      (w_ip_masked[2]) w_cause = 32'h8000_000B;
            else if (w_ip_masked[0]) w_cause = 32'h8000_0003;
            else                     w_cause = 32'h8000_0007;
        end
        // Vectored mode offsets interrupts only; exceptions use the base
        w_target = {mtvec[31:2], 2'b00};
        if (!w_any_exc && (mtvec[1:0] == 2'b01))
            w_target = {mtvec[31:2], 2'b00} + {25'd0, w_cause[4:0], 2'b00};
    end

    // Trap context latches; held frozen until the next trap is accepted
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_cause     <= 32'd0;
            r_epc       <= 32'd0;
            r_tval      <= 32'd0;
            r_target    <= 32'd0;
            r_from_trap <= 1'b0;
        end else if (w_take_trap) begin
            r_cause     <= w_cause;
            r_epc       <= epc;
            r_tval      <= w_tval;
            r_target    <= w_target;
            r_from_trap <= 1'b1;
        end else if (w_take_ret) begin
            r_from_trap <= 1'b0;
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and strobe decode
    always_comb begin
        w_next_state = r_state;
        intr         = 1'b0;
        insert_pc    = 1'b0;
        trap_we      = 1'b0;
        mret_we      = 1'b0;
        priv_pc      = 32'd0;
        case (r_state)
            c_IDLE: begin
                if      (w_take_trap) w_next_state = c_TRAP_WAIT;
                else if (w_take_ret)  w_next_state = c_RET_WAIT;
            end
            c_TRAP_WAIT: begin
                intr = 1'b1;
                if (pipe_clear) w_next_state = c_REDIRECT;
            end
            c_RET_WAIT: begin
                if (pipe_clear) w_next_state = c_REDIRECT;
            end
            default: begin
                insert_pc    = 1'b1;
                trap_we      = r_from_trap;
                mret_we      = ~r_from_trap;
                priv_pc      = r_from_trap ? r_target : mepc_r;
                w_next_state = c_IDLE;
            end
        endcase
    end

    assign trap_cause = r_cause;
    assign trap_epc   = r_epc;
    assign trap_tval  = r_tval;

    // Any locally enabled pending interrupt wakes the core, even with MIE clear
    assign wfi_stall = wfi & (r_state == c_IDLE) & (w_ip_masked == 3'b000);

endmodule
`default_nettype wire

// File: tb/tb_priv_trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priv_trap_controller
//  Description : Self-checking bench for priv_trap_controller: directed
//                scenarios followed by randomized transactions compared
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priv_trap_controller;

    logic        CLK;
    logic        nRST;
    logic        fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
    logic        breakpoint, env, prot_fault_i, prot_fault_l, prot_fault_s, ex_rmgmt;
    logic [0:0]  ex_rmgmt_cause;
    logic        ret, wfi, pipe_clear, timer_int, soft_int, ext_int, mstatus_mie;
    logic [31:0] epc, badaddr, mtvec, mepc_r;
    logic [2:0]  mie_bits;
    logic        intr, insert_pc, trap_we, mret_we, wfi_stall;
    logic [31:0] priv_pc, trap_cause, trap_epc, trap_tval;

    int n_checks = 0;
    int n_fails  = 0;

    priv_trap_controller #(.NUM_EXTENSIONS(1), .RMGMT_CAUSE_BASE(24)) dut (
        .CLK(CLK), .nRST(nRST),
        .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
        .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s),
        .breakpoint(breakpoint), .env(env),
        .prot_fault_i(prot_fault_i), .prot_fault_l(prot_fault_l), .prot_fault_s(prot_fault_s),
        .ex_rmgmt(ex_rmgmt), .ex_rmgmt_cause(ex_rmgmt_cause),
        .ret(ret), .wfi(wfi), .epc(epc), .badaddr(badaddr), .pipe_clear(pipe_clear),
        .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int),
        .mstatus_mie(mstatus_mie), .mie_bits(mie_bits), .mtvec(mtvec), .mepc_r(mepc_r),
        .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc),
        .trap_we(trap_we), .mret_we(mret_we),
        .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
        .wfi_stall(wfi_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_exc();
        fault_insn = 0; mal_insn = 0; illegal_insn = 0; fault_l = 0; mal_l = 0;
        fault_s = 0; mal_s = 0; breakpoint = 0; env = 0; prot_fault_i = 0;
        prot_fault_l = 0; prot_fault_s = 0; ex_rmgmt = 0; ex_rmgmt_cause = 1'b0;
        ret = 0;
    endtask

    task automatic clear_all();
        clear_exc();
        wfi = 0; pipe_clear = 0; timer_int = 0; soft_int = 0; ext_int = 0;
        mstatus_mie = 0; mie_bits = 3'b000; epc = 0; badaddr = 0; mtvec = 0; mepc_r = 0;
    endtask

    // v: 0 fault_insn, 1 illegal, 2 mal_insn, 3 env, 4 breakpoint, 5 mal_s,
    //    6 mal_l, 7 fault_s, 8 fault_l, 9 ex_rmgmt, 10 prot_i, 11 prot_s, 12 prot_l
    task automatic drive_exc(input logic [12:0] v);
        fault_insn = v[0]; illegal_insn = v[1]; mal_insn = v[2]; env = v[3];
        breakpoint = v[4]; mal_s = v[5]; mal_l = v[6]; fault_s = v[7]; fault_l = v[8];
        ex_rmgmt = v[9]; prot_fault_i = v[10]; prot_fault_s = v[11]; prot_fault_l = v[12];
    endtask

    // Reference: first raised exception in the architectural priority list
    function automatic int model_exc_cause(input logic [12:0] v, input logic rc);
        logic [9:0] eff;
        int codes [10];
        eff = v[9:0];
        eff[0] = v[0] | v[10];
        eff[7] = v[7] | v[11];
        eff[8] = v[8] | v[12];
        codes = '{1, 2, 0, 11, 3, 6, 4, 7, 5, 24 + int'(rc)};
        for (int i = 0; i < 10; i++)
            if (eff[i]) return codes[i];
        return -1;
    endfunction

    function automatic logic [31:0] model_tval(input int cause, input logic [31:0] pc,
                                               input logic [31:0] addr);
        if (cause == 0 || cause == 1 || (cause >= 4 && cause <= 7)) return addr;
        if (cause == 3) return pc;
        return 32'd0;
    endfunction

    // Reference: enabled interrupt code (ext > soft > timer), -1 when none
    function automatic int model_int_code(input logic e, input logic t, input logic s,
                                          input logic [2:0] en, input logic gie);
        if (!gie) return -1;
        if (e && en[2]) return 11;
        if (s && en[0]) return 3;
        if (t && en[1]) return 7;
        return -1;
    endfunction

    initial begin
        logic [12:0] v;
        logic        rc, e_l, t_l, s_l, r_l, gie, is_int;
        logic [2:0]  en;
        logic [31:0] pc_v, addr_v, tvec_v, mepc_v, exp_cause, exp_tval, exp_pc;
        int          ec, ic, waitn;

        clear_all();
        nRST = 1'b0;
        tick();
        tick();
        // ---------------- reset state ----------------
        chk("rst_intr", {31'd0, intr}, 32'd0);
        chk("rst_insert_pc", {31'd0, insert_pc}, 32'd0);
        chk("rst_priv_pc", priv_pc, 32'd0);
        chk("rst_trap_we", {31'd0, trap_we}, 32'd0);
        chk("rst_mret_we", {31'd0, mret_we}, 32'd0);
        chk("rst_cause", trap_cause, 32'd0);
        chk("rst_epc", trap_epc, 32'd0);
        chk("rst_tval", trap_tval, 32'd0);
        chk("rst_wfi_stall", {31'd0, wfi_stall}, 32'd0);
        nRST = 1'b1;

        // ---------------- illegal instruction ----------------
        illegal_insn = 1; epc = 32'h100; mtvec = 32'h200; badaddr = 32'hDEAD;
        tick();
        clear_exc();
        chk("ill_intr", {31'd0, intr}, 32'd1);
        chk("ill_cause", trap_cause, 32'd2);
        chk("ill_tval", trap_tval, 32'd0);
        chk("ill_epc", trap_epc, 32'h100);
        tick();
        tick();
        chk("ill_wait_insert", {31'd0, insert_pc}, 32'd0);
        pipe_clear = 1;
        tick();
        pipe_clear = 0;
        chk("ill_insert", {31'd0, insert_pc}, 32'd1);
        chk("ill_trap_we", {31'd0, trap_we}, 32'd1);
        chk("ill_priv_pc", priv_pc, 32'h200);
        chk("ill_redirect_intr", {31'd0, intr}, 32'd0);
        tick();
        chk("ill_insert_one_cycle", {31'd0, insert_pc}, 32'd0);

        // ---------------- priority: fault_insn over mal_l ----------------
        mal_l = 1; fault_insn = 1; badaddr = 32'h1003; epc = 32'h140;
        tick();
        clear_exc();
        chk("pri_cause", trap_cause, 32'd1);
        chk("pri_tval", trap_tval, 32'h1003);
        pipe_clear = 1;
        tick();
        pipe_clear = 0;
        chk("pri_insert", {31'd0, insert_pc}, 32'd1);
        tick();

        // ---------------- vectored external interrupt ----------------
        ext_int = 1; timer_int = 1; mie_bits = 3'b111; mstatus_mie = 1; mtvec = 32'h401;
        tick();
        chk("irq_sync_delay", {31'd0, intr}, 32'd0);
        tick();
        chk("irq_intr", {31'd0, intr}, 32'd1);
        chk("irq_cause", trap_cause, 32'h8000000B);
        chk("irq_tval", trap_tval, 32'd0);
        ext_int = 0; timer_int = 0; pipe_clear = 1;
        tick();
        pipe_clear = 0;
        chk("irq_priv_pc", priv_pc, 32'h42C);
        chk("irq_trap_we", {31'd0, trap_we}, 32'd1);
        tick();

        // ---------------- interrupt masked globally ----------------
        ext_int = 1; timer_int = 1; mstatus_mie = 0;
        tick(); tick(); tick();
        chk("irq_masked_intr", {31'd0, intr}, 32'd0);
        ext_int = 0; timer_int = 0;
        tick(); tick();

        // ---------------- mret ----------------
        ret = 1;
        tick();
        ret = 0;
        chk("ret_wait_intr", {31'd0, intr}, 32'd0);
        pipe_clear = 1; mepc_r = 32'h80;
        tick();
        pipe_clear = 0;
        chk("ret_mret_we", {31'd0, mret_we}, 32'd1);
        chk("ret_trap_we", {31'd0, trap_we}, 32'd0);
        chk("ret_insert", {31'd0, insert_pc}, 32'd1);
        chk("ret_priv_pc", priv_pc, 32'h80);
        tick();

        // ---------------- exception and ret together: trap wins ----------------
        ret = 1; breakpoint = 1; epc = 32'h300; mtvec = 32'h200;
        tick();
        clear_exc();
        chk("exret_cause", trap_cause, 32'd3);
        chk("exret_tval", trap_tval, 32'h300);
        pipe_clear = 1;
        tick();
        pipe_clear = 0;
        chk("exret_trap_we", {31'd0, trap_we}, 32'd1);
        chk("exret_mret_we", {31'd0, mret_we}, 32'd0);
        tick();

        // ---------------- pipe_clear in IDLE is ignored ----------------
        pipe_clear = 1;
        tick();
        chk("idle_clear_insert", {31'd0, insert_pc}, 32'd0);
        pipe_clear = 0;

        // ---------------- reset mid-trap abandons it ----------------
        env = 1; epc = 32'h500;
        tick();
        clear_exc();
        nRST = 0; pipe_clear = 1;
        tick();
        chk("midrst_insert", {31'd0, insert_pc}, 32'd0);
        chk("midrst_cause", trap_cause, 32'd0);
        nRST = 1;
        tick();
        chk("midrst_no_strobe", {31'd0, trap_we}, 32'd0);
        pipe_clear = 0;

        // ---------------- wfi ----------------
        wfi = 1; mie_bits = 3'b001; mstatus_mie = 0;
        #1;
        chk("wfi_stall_on", {31'd0, wfi_stall}, 32'd1);
        soft_int = 1;
        #1;
        chk("wfi_stall_before_sample", {31'd0, wfi_stall}, 32'd1);
        tick();
        chk("wfi_wake", {31'd0, wfi_stall}, 32'd0);
        chk("wfi_no_trap", {31'd0, intr}, 32'd0);
        clear_all();
        tick(); tick();

        // ---------------- randomized transactions ----------------
        for (int n = 0; n < 300; n++) begin
            e_l = ($urandom_range(0, 2) == 0);
            t_l = ($urandom_range(0, 2) == 0);
            s_l = ($urandom_range(0, 2) == 0);
            en  = 3'($urandom);
            gie = 1'($urandom);
            tvec_v = $urandom;
            ext_int = e_l; timer_int = t_l; soft_int = s_l;
            mie_bits = en; mstatus_mie = gie; mtvec = tvec_v;
            tick();
            for (int b = 0; b < 13; b++) v[b] = ($urandom_range(0, 11) == 0);
            rc = 1'($urandom);
            r_l = 1'($urandom);
            pc_v = $urandom; addr_v = $urandom;
            drive_exc(v); ex_rmgmt_cause = rc; ret = r_l; epc = pc_v; badaddr = addr_v;
            tick();
            clear_exc();
            ext_int = 0; timer_int = 0; soft_int = 0;
            ec = model_exc_cause(v, rc);
            ic = model_int_code(e_l, t_l, s_l, en, gie);
            waitn = $urandom_range(0, 3);
            if (ec >= 0 || ic >= 0) begin
                is_int    = (ec < 0);
                exp_cause = is_int ? (32'h8000_0000 | 32'(ic)) : 32'(ec);
                exp_tval  = is_int ? 32'd0 : model_tval(ec, pc_v, addr_v);
                exp_pc    = {tvec_v[31:2], 2'b00};
                if (is_int && tvec_v[1:0] == 2'b01) exp_pc = exp_pc + 32'(4 * ic);
                chk("rnd_intr", {31'd0, intr}, 32'd1);
                chk("rnd_cause", trap_cause, exp_cause);
                chk("rnd_epc", trap_epc, pc_v);
                chk("rnd_tval", trap_tval, exp_tval);
                // New flags while committed must be ignored
                for (int w = 0; w < waitn; w++) begin
                    for (int b = 0; b < 13; b++) v[b] = ($urandom_range(0, 3) == 0);
                    drive_exc(v); ret = 1'($urandom); epc = $urandom; badaddr = $urandom;
                    tick();
                end
                clear_exc();
                mtvec = $urandom;
                pipe_clear = 1;
                tick();
                pipe_clear = 0;
                chk("rnd_trap_insert", {31'd0, insert_pc}, 32'd1);
                chk("rnd_trap_we", {31'd0, trap_we}, 32'd1);
                chk("rnd_trap_pc", priv_pc, exp_pc);
                chk("rnd_trap_cause_hold", trap_cause, exp_cause);
            end else if (r_l) begin
                chk("rnd_ret_intr", {31'd0, intr}, 32'd0);
                for (int w = 0; w < waitn; w++) begin
                    chk("rnd_ret_wait_insert", {31'd0, insert_pc}, 32'd0);
                    tick();
                end
                mepc_v = $urandom;
                mepc_r = mepc_v; pipe_clear = 1;
                tick();
                pipe_clear = 0;
                chk("rnd_mret_we", {31'd0, mret_we}, 32'd1);
                chk("rnd_ret_pc", priv_pc, mepc_v);
            end else begin
                chk("rnd_idle_intr", {31'd0, intr}, 32'd0);
                chk("rnd_idle_insert", {31'd0, insert_pc}, 32'd0);
            end
            tick();
            chk("rnd_back_idle", {31'd0, insert_pc | intr}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
